// File: rtl/bcd_conv_scheduler.sv
// bcd_conv_scheduler: round-robin time-sharing of one serial binary-to-BCD converter among N requesters.
module bcd_conv_scheduler #(
  parameter int N           = 4,
  parameter int CONV_CYCLES = 15,
  parameter int MAX_VAL     = 9999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [14*N-1:0]   bin_in,
  output logic              conv_start,
  output logic [13:0]       conv_in,
  input  logic [15:0]       conv_bcd,
  output logic [16*N-1:0]   bcd_out,
  output logic [N-1:0]      done,
  output logic [N-1:0]      clamped,
  output logic              busy,
  output logic [2:0]        grant_idx
);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;
  state_t          state_q, state_d;
  logic [2:0]      rr_q, rr_d, grant_q, grant_d, sel;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [13:0]     conv_in_q, conv_in_d, sel_bin;
  logic            sat_q, sat_d, found;
  logic [16*N-1:0] bcd_q, bcd_d;
  logic [N-1:0]    clamped_q, clamped_d;
  // first pending requester at or above rr_q, wrapping past N-1 to 0
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++)
      if (!found && req[(int'(rr_q) + k) % N]) begin
        sel = 3'((int'(rr_q) + k) % N);
        found = 1'b1;
      end
  end
  assign sel_bin = bin_in[14*int'(sel) +: 14];
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    conv_in_d = conv_in_q;
    sat_d = sat_q;
    bcd_d = bcd_q;
    clamped_d = clamped_q;
    case (state_q)
      IDLE:
        if (found) begin
          grant_d = sel;
          sat_d = int'(sel_bin) > MAX_VAL;
          conv_in_d = sat_d ? 14'(MAX_VAL) : sel_bin;
          state_d = START;
        end
      START: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(CONV_CYCLES - 1)) begin
          bcd_d[16*int'(grant_q) +: 16] = conv_bcd;
          clamped_d[grant_q] = sat_q;
          state_d = DONE;
        end
      end
      DONE: begin
        rr_d = (int'(grant_q) == N - 1) ? 3'd0 : grant_q + 3'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rr_q <= '0;
      grant_q <= '0;
      cnt_q <= '0;
      conv_in_q <= '0;
      sat_q <= 1'b0;
      bcd_q <= '0;
      clamped_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      conv_in_q <= conv_in_d;
      sat_q <= sat_d;
      bcd_q <= bcd_d;
      clamped_q <= clamped_d;
    end
  assign conv_start = state_q == START;
  assign busy = state_q != IDLE;
  assign done = (state_q == DONE) ? N'(1) << grant_q : '0;
  assign conv_in = conv_in_q;
  assign bcd_out = bcd_q;
  assign clamped = clamped_q;
  assign grant_idx = grant_q;
endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// tb_bcd_conv_scheduler: directed and random jobs checked against an arithmetic round-robin/BCD model.
module tb_bcd_conv_scheduler;
  localparam int N = 4, CC = 15, MAXV = 9999;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [14*N-1:0] bin_in = '0;
  logic conv_start, busy;
  logic [13:0] conv_in;
  logic [15:0] conv_bcd;
  logic [16*N-1:0] bcd_out;
  logic [N-1:0] done, clamped;
  logic [2:0] grant_idx;
  int tests = 0, fails = 0;
  int rr_m = 0;
  int val_m [N];
  logic [N-1:0] clamp_m = '0;
  int order [$];
  int cv_val = 0, cv_cnt = 0;
  bit cv_run = 1'b0, restart_err = 1'b0;

  always #5 clk = ~clk;

  bcd_conv_scheduler #(.N(N), .CONV_CYCLES(CC), .MAX_VAL(MAXV)) dut (
    .clk(clk), .reset(reset), .req(req), .bin_in(bin_in), .conv_start(conv_start),
    .conv_in(conv_in), .conv_bcd(conv_bcd), .bcd_out(bcd_out), .done(done),
    .clamped(clamped), .busy(busy), .grant_idx(grant_idx));

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // converter stand-in: result only valid from the 15th cycle after start
  always @(posedge clk or posedge reset)
    if (reset) begin
      cv_run <= 1'b0;
      cv_cnt <= 0;
      cv_val <= 0;
    end else if (conv_start) begin
      if (cv_run && cv_cnt < CC - 1) restart_err <= 1'b1;
      cv_val <= int'(conv_in);
      cv_cnt <= 0;
      cv_run <= 1'b1;
    end else if (cv_run) cv_cnt <= cv_cnt + 1;
  assign conv_bcd = (cv_run && cv_cnt >= CC - 1) ? to_bcd(cv_val) : 16'hFFFF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_grant(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [16*N-1:0] model_vec();
    logic [16*N-1:0] r;
    for (int i = 0; i < N; i++) r[16*i +: 16] = to_bcd(val_m[i]);
    return r;
  endfunction

  function automatic logic [14*N-1:0] rand_bin();
    logic [14*N-1:0] r;
    for (int i = 0; i < N; i++) r[14*i +: 14] = 14'($urandom_range(0, 16383));
    return r;
  endfunction

  task automatic reset_model();
    rr_m = 0;
    clamp_m = '0;
    for (int i = 0; i < N; i++) val_m[i] = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cs"}, 64'(conv_start), 64'(0));
    chk({tag, "_ci"}, 64'(conv_in), 64'(0));
    chk({tag, "_bcd"}, 64'(bcd_out), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_clamp"}, 64'(clamped), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_gi"}, 64'(grant_idx), 64'(0));
  endtask

  // starts in an IDLE cycle with req nonzero; ends in the IDLE cycle after DONE
  task automatic do_job(input logic [N-1:0] req_wait, input logic [N-1:0] req_done, input bit chg);
    int idx, v, e, bad;
    logic [N-1:0] oh;
    idx = next_grant(req, rr_m);
    v = int'(bin_in[14*idx +: 14]);
    e = v > MAXV ? MAXV : v;
    tick();
    chk("start", 64'(conv_start), 64'(1));
    chk("grant", 64'(grant_idx), 64'(idx));
    chk("conv_in", 64'(conv_in), 64'(e));
    order.push_back(int'(grant_idx));
    bad = 0;
    for (int i = 0; i < CC; i++) begin
      tick();
      if (conv_start !== 1'b0 || done !== '0 || busy !== 1'b1) bad++;
      if (i == 7) begin
        req = req_wait;
        if (chg) bin_in = rand_bin();
      end
    end
    chk("wait", 64'(bad), 64'(0));
    tick();
    oh = '0;
    oh[idx] = 1'b1;
    val_m[idx] = e;
    clamp_m[idx] = v > MAXV;
    chk("done", 64'(done), 64'(oh));
    chk("bcd_slot", 64'(bcd_out[16*idx +: 16]), 64'(to_bcd(e)));
    chk("bcd_all", 64'(bcd_out), 64'(model_vec()));
    chk("clamped", 64'(clamped), 64'(clamp_m));
    chk("busy_done", 64'(busy), 64'(1));
    rr_m = (idx + 1) % N;
    req = req_done;
    tick();
    chk("idle_done", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int bad, nx;
    int exp_c [5] = '{0, 1, 2, 3, 0};
    int exp_f [4] = '{2, 0, 2, 0};
    reset_model();
    tick();
    tick();
    chk_zero("rst");
    reset = 1'b0;
    tick();
    chk_zero("rel");

    bin_in[13:0] = 14'd1234;
    req = 4'b0001;
    do_job(4'b0001, 4'b0000, 1'b0);
    chk("single", 64'(bcd_out[15:0]), 64'h1234);

    bin_in[27:14] = 14'd16383;
    req = 4'b0010;
    do_job(4'b0010, 4'b0000, 1'b0);
    chk("sat_bcd", 64'(bcd_out[31:16]), 64'h9999);
    chk("sat_flag", 64'(clamped[1]), 64'(1));
    bin_in[27:14] = 14'd0;
    req = 4'b0010;
    do_job(4'b0010, 4'b0000, 1'b0);
    chk("zero_bcd", 64'(bcd_out[31:16]), 64'h0);
    chk("zero_flag", 64'(clamped[1]), 64'(0));

    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_model();
    tick();
    bin_in = {14'd4444, 14'd333, 14'd22, 14'd1};
    req = 4'b1111;
    order.delete();
    repeat (4) do_job(4'b1111, 4'b1111, 1'b0);
    do_job(4'b1111, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) chk("cont_order", 64'(order[i]), 64'(exp_c[i]));
    chk("cont_slots", 64'(bcd_out), 64'h4444_0333_0022_0001);

    order.delete();
    bin_in = rand_bin();
    req = 4'b0101;
    do_job(4'b0101, 4'b0101, 1'b1);
    do_job(4'b0101, 4'b0100, 1'b0);
    do_job(4'b0101, 4'b0101, 1'b1);
    do_job(4'b0101, 4'b0000, 1'b0);
    for (int i = 0; i < 4; i++) chk("fair_order", 64'(order[i]), 64'(exp_f[i]));

    bin_in = rand_bin();
    req = 4'b0001;
    do_job(4'b0000, 4'b0000, 1'b1);
    bad = 0;
    repeat (20) begin
      tick();
      if (conv_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("no_regrant", 64'(bad), 64'(0));

    repeat (10) begin
      if (req == '0) req = 4'($urandom_range(1, 15));
      bin_in = rand_bin();
      nx = next_grant(req, rr_m);
      do_job(req, req & ~(4'b0001 << nx), 1'($urandom_range(0, 1)));
    end
    req = '0;
    tick();

    bin_in = rand_bin();
    req = 4'b0010;
    tick();
    repeat (7) tick();
    reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    req = '0;
    tick();
    reset = 1'b0;
    reset_model();
    bad = 0;
    repeat (25) begin
      tick();
      if (conv_start !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("post_rst_idle", 64'(bad), 64'(0));
    chk("post_rst_bcd", 64'(bcd_out), 64'(0));
    chk("no_restart", 64'(restart_err), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
